unframer: RTL and testbench

//  Receive-side counterpart of the framing escaper. Takes a raw AXI4-Stream byte

---
 rtl/unframer.sv | 145 ++++++++++++++
 tb/tb_unframer.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unframer.sv
// Receive-side unframer: strips START/STOP delimiters and escape prefixes from a
// raw byte stream and emits each frame as one AXI4-Stream packet with tlast.
module unframer #(
  parameter logic [7:0] ESCAPE_BYTE = 8'h7F,
  parameter logic [7:0] START_BYTE  = 8'h7D,
  parameter logic [7:0] STOP_BYTE   = 8'h7E
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       target_tvalid,
  output logic       target_tready,
  input  logic [7:0] target_tdata,
  input  logic       target_tlast,
  output logic       initiator_tvalid,
  input  logic       initiator_tready,
  output logic [7:0] initiator_tdata,
  output logic       initiator_tlast,
  output logic       frame_error
);

  // state  | meaning
  // HUNT   | outside a frame, discarding bytes until START
  // DATA   | inside a frame, next byte is payload or a control byte
  // ESC    | previous byte was ESCAPE, next byte is taken literally
  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_DATA = 2'd1,
    S_ESC  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       h_valid_q;
  logic [7:0] h_data_q;
  logic       o_valid_q;
  logic [7:0] o_data_q;
  logic       o_last_q;
  logic       err_q, err_d;

  logic       accept;
  logic       push, push_last;
  logic       h_load, h_clr;
  logic       is_special;

  logic       unused_tlast;
  assign unused_tlast = target_tlast;

  assign target_tready = aresetn && (!o_valid_q || initiator_tready);
  assign accept        = target_tvalid && target_tready;
  assign is_special    = (target_tdata == START_BYTE) || (target_tdata == STOP_BYTE) ||
                         (target_tdata == ESCAPE_BYTE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        S_HUNT: if (target_tdata == START_BYTE) state_d = S_DATA;
        S_DATA: begin
          if (target_tdata == ESCAPE_BYTE)    state_d = S_ESC;
          else if (target_tdata == STOP_BYTE) state_d = S_HUNT;
        end
        S_ESC:   state_d = S_DATA;
        default: state_d = S_HUNT;
      endcase
    end
  end

  // The held byte is only released once the following byte tells us whether it closes the frame.
  always_comb begin
    push      = 1'b0;
    push_last = 1'b0;
    h_load    = 1'b0;
    h_clr     = 1'b0;
    err_d     = 1'b0;
    if (accept) begin
      case (state_q)
        S_HUNT: if (target_tdata == START_BYTE) h_clr = 1'b1;
        S_DATA: begin
          if (target_tdata == ESCAPE_BYTE) begin
            push = 1'b0;
          end else if (target_tdata == STOP_BYTE) begin
            push      = h_valid_q;
            push_last = h_valid_q;
            h_clr     = 1'b1;
            err_d     = !h_valid_q;
          end else if (target_tdata == START_BYTE) begin
            push      = h_valid_q;
            push_last = h_valid_q;
            h_clr     = 1'b1;
            err_d     = h_valid_q;
          end else begin
            push   = h_valid_q;
            h_load = 1'b1;
          end
        end
        S_ESC: begin
          push   = h_valid_q;
          h_load = 1'b1;
          err_d  = !is_special;
        end
        default: h_clr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      h_valid_q <= 1'b0;
      h_data_q  <= 8'h00;
      o_valid_q <= 1'b0;
      o_data_q  <= 8'h00;
      o_last_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (h_load) begin
        h_valid_q <= 1'b1;
        h_data_q  <= target_tdata;
      end else if (h_clr) begin
        h_valid_q <= 1'b0;
      end
      // A push only happens when O is empty or being drained this cycle, so no bubble.
      if (push) begin
        o_valid_q <= 1'b1;
        o_data_q  <= h_data_q;
        o_last_q  <= push_last;
      end else if (initiator_tready) begin
        o_valid_q <= 1'b0;
      end
      err_q <= err_d;
    end
  end

  assign initiator_tvalid = o_valid_q;
  assign initiator_tdata  = o_data_q;
  assign initiator_tlast  = o_last_q;
  assign frame_error      = err_q;

endmodule

// File: tb/tb_unframer.sv
// Self-checking bench for unframer: directed frames, throughput, random frames
// with backpressure against a frame-level reference model, and mid-frame reset.
module tb_unframer;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       target_tvalid = 1'b0;
  logic       target_tready;
  logic [7:0] target_tdata = 8'h00;
  logic       target_tlast = 1'b0;
  logic       initiator_tvalid;
  logic       initiator_tready = 1'b1;
  logic [7:0] initiator_tdata;
  logic       initiator_tlast;
  logic       frame_error;

  unframer dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .target_tvalid    (target_tvalid),
    .target_tready    (target_tready),
    .target_tdata     (target_tdata),
    .target_tlast     (target_tlast),
    .initiator_tvalid (initiator_tvalid),
    .initiator_tready (initiator_tready),
    .initiator_tdata  (initiator_tdata),
    .initiator_tlast  (initiator_tlast),
    .frame_error      (frame_error)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
  int err_seen = 0;
  logic [8:0] obs[$];   // {tlast, tdata}
  logic [8:0] exp_q[$];
  int exp_errs;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic ready_loop();
    forever begin
      @(posedge aclk);
      #2;
      case (ready_mode)
        0:       initiator_tready = 1'b1;
        1:       initiator_tready = 1'($urandom_range(0, 1));
        default: initiator_tready = 1'b0;
      endcase
    end
  endtask

  task automatic monitor_loop();
    logic       prev_stall;
    logic [8:0] prev_o;
    prev_stall = 1'b0;
    prev_o = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          total++;
          if ({initiator_tvalid, initiator_tlast, initiator_tdata} !== {1'b1, prev_o}) begin
            bad++;
            $display("FAIL stall_hold: got v=%0b last=%0b data=%h, held was last=%0b data=%h",
                     initiator_tvalid, initiator_tlast, initiator_tdata, prev_o[8], prev_o[7:0]);
          end
        end
        if (initiator_tvalid && initiator_tready) obs.push_back({initiator_tlast, initiator_tdata});
        if (frame_error) err_seen++;
        prev_stall = initiator_tvalid && !initiator_tready;
        prev_o = {initiator_tlast, initiator_tdata};
      end
    end
  endtask

  // Frame-level reference: collect a frame's payload, release it when the frame closes.
  function automatic void model(input logic [7:0] s[$]);
    logic [7:0] pl[$];
    logic [7:0] b;
    bit in_f;
    bit esc;
    in_f = 0;
    esc = 0;
    exp_q.delete();
    exp_errs = 0;
    foreach (s[i]) begin
      b = s[i];
      if (!in_f) begin
        if (b == 8'h7D) begin
          in_f = 1;
          pl.delete();
        end
      end else if (esc) begin
        esc = 0;
        if (!(b inside {8'h7D, 8'h7E, 8'h7F})) exp_errs++;
        pl.push_back(b);
      end else if (b == 8'h7F) begin
        esc = 1;
      end else if (b == 8'h7E || b == 8'h7D) begin
        if (pl.size() == 0) begin
          if (b == 8'h7E) exp_errs++;
        end else begin
          foreach (pl[k]) exp_q.push_back({(k == pl.size() - 1), pl[k]});
          if (b == 8'h7D) exp_errs++;
        end
        pl.delete();
        if (b == 8'h7E) in_f = 0;
      end else begin
        pl.push_back(b);
      end
    end
  endfunction

  task automatic send_stream(input logic [7:0] s[$], input int gap_max);
    int waitc;
    int g;
    foreach (s[i]) begin
      waitc = 0;
      target_tvalid = 1'b1;
      target_tdata = s[i];
      @(negedge aclk);
      while (!target_tready) begin
        waitc++;
        if (waitc > 500) begin
          total++;
          bad++;
          $display("FAIL send_timeout: byte %0d not accepted, got tready=%0b, want 1", i, target_tready);
          target_tvalid = 1'b0;
          return;
        end
        @(negedge aclk);
      end
      @(posedge aclk);
      #1;
      target_tvalid = 1'b0;
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      repeat (g) begin
        @(posedge aclk);
        #1;
      end
    end
  endtask

  task automatic drain(input int n_exp);
    int c;
    c = 0;
    while (obs.size() < n_exp && c < 3000) begin
      @(negedge aclk);
      c++;
    end
    repeat (4) @(negedge aclk);
  endtask

  task automatic clear_obs();
    @(negedge aclk);
    obs.delete();
    err_seen = 0;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    target_tvalid = 1'b1;
    target_tdata = 8'h7D;
    repeat (3) @(negedge aclk);
    total++;
    if ({initiator_tvalid, initiator_tdata, initiator_tlast, frame_error, target_tready} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs: got v=%0b d=%h l=%0b err=%0b trdy=%0b, want all 0",
               initiator_tvalid, initiator_tdata, initiator_tlast, frame_error, target_tready);
    end
    target_tvalid = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    total++;
    if (target_tready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_tready: got %0b want 1", target_tready);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_basic();
    logic [7:0] s[$];
    logic [8:0] e[$];
    s = '{8'h7D, 8'h41, 8'h42, 8'h7E};
    e = '{9'h041, 9'h142};
    clear_obs();
    send_stream(s, 0);
    drain(e.size());
    total++;
    if (obs.size() !== e.size()) begin
      bad++;
      $display("FAIL basic_count: got %0d want %0d", obs.size(), e.size());
    end
    foreach (e[i]) begin
      total++;
      if (i >= obs.size() || obs[i] !== e[i]) begin
        bad++;
        $display("FAIL basic_byte%0d: got %h want %h", i, (i < obs.size()) ? obs[i] : 9'h1FF, e[i]);
      end
    end
    total++;
    if (err_seen !== 0) begin
      bad++;
      $display("FAIL basic_err: got %0d want 0", err_seen);
    end
  endtask

  task automatic test_escape();
    logic [7:0] s[$];
    logic [8:0] e[$];
    s = '{8'h7D, 8'h7F, 8'h7D, 8'h7F, 8'h7F, 8'h7F, 8'h7E, 8'h7E};
    e = '{9'h07D, 9'h07F, 9'h17E};
    clear_obs();
    send_stream(s, 1);
    drain(e.size());
    total++;
    if (obs.size() !== e.size()) begin
      bad++;
      $display("FAIL escape_count: got %0d want %0d", obs.size(), e.size());
    end
    foreach (e[i]) begin
      total++;
      if (i >= obs.size() || obs[i] !== e[i]) begin
        bad++;
        $display("FAIL escape_byte%0d: got %h want %h", i, (i < obs.size()) ? obs[i] : 9'h1FF, e[i]);
      end
    end
    total++;
    if (err_seen !== 0) begin
      bad++;
      $display("FAIL escape_err: got %0d want 0", err_seen);
    end
  endtask

  task automatic test_junk();
    logic [7:0] s[$];
    logic [8:0] e[$];
    s = '{8'h00, 8'h55, 8'h7E, 8'h7D, 8'h10, 8'h7E};
    e = '{9'h110};
    clear_obs();
    send_stream(s, 0);
    drain(e.size());
    total++;
    if (obs.size() !== 1 || obs[0] !== e[0]) begin
      bad++;
      $display("FAIL junk_out: got n=%0d first=%h want n=1 first=%h", obs.size(),
               (obs.size() > 0) ? obs[0] : 9'h1FF, e[0]);
    end
    total++;
    if (err_seen !== 0) begin
      bad++;
      $display("FAIL junk_err: got %0d want 0", err_seen);
    end
  endtask

  task automatic test_errors();
    logic [7:0] s[$];
    s = '{8'h7D, 8'h7E};
    clear_obs();
    send_stream(s, 0);
    drain(0);
    total++;
    if (obs.size() !== 0 || err_seen !== 1) begin
      bad++;
      $display("FAIL empty_frame: got out=%0d err_cycles=%0d want out=0 err_cycles=1", obs.size(), err_seen);
    end
    s = '{8'h7D, 8'h7F, 8'h33, 8'h7E};
    clear_obs();
    send_stream(s, 0);
    drain(1);
    total++;
    if (obs.size() !== 1 || obs[0] !== 9'h133 || err_seen !== 1) begin
      bad++;
      $display("FAIL bad_escape: got out=%0d first=%h err_cycles=%0d want out=1 first=133 err_cycles=1",
               obs.size(), (obs.size() > 0) ? obs[0] : 9'h1FF, err_seen);
    end
  endtask

  task automatic test_truncated();
    logic [7:0] s[$];
    logic [8:0] e[$];
    s = '{8'h7D, 8'h01, 8'h02, 8'h7D, 8'h03, 8'h7E};
    e = '{9'h001, 9'h102, 9'h103};
    clear_obs();
    send_stream(s, 0);
    drain(e.size());
    total++;
    if (obs.size() !== e.size()) begin
      bad++;
      $display("FAIL trunc_count: got %0d want %0d", obs.size(), e.size());
    end
    foreach (e[i]) begin
      total++;
      if (i >= obs.size() || obs[i] !== e[i]) begin
        bad++;
        $display("FAIL trunc_byte%0d: got %h want %h", i, (i < obs.size()) ? obs[i] : 9'h1FF, e[i]);
      end
    end
    total++;
    if (err_seen !== 1) begin
      bad++;
      $display("FAIL trunc_err: got %0d want 1", err_seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s[$];
    int c0;
    int n_ok;
    s.push_back(8'h7D);
    for (int i = 0; i < 10; i++) s.push_back(8'($urandom_range(0, 8'h7C)));
    s.push_back(8'h7E);
    model(s);
    clear_obs();
    c0 = cyc;
    send_stream(s, 0);
    total++;
    if (cyc - c0 !== s.size()) begin
      bad++;
      $display("FAIL throughput: got %0d cycles for %0d bytes, want %0d", cyc - c0, s.size(), s.size());
    end
    drain(exp_q.size());
    n_ok = 0;
    foreach (exp_q[i]) if (i < obs.size() && obs[i] === exp_q[i]) n_ok++;
    total++;
    if (obs.size() !== exp_q.size() || n_ok !== exp_q.size()) begin
      bad++;
      $display("FAIL b2b_payload: got n=%0d matching=%0d want n=%0d", obs.size(), n_ok, exp_q.size());
    end
  endtask

  task automatic test_random();
    logic [7:0] s[$];
    logic [7:0] b;
    int len;
    int nbad;
    for (int f = 0; f < 200; f++) begin
      if ($urandom_range(0, 5) == 0) begin
        b = 8'($urandom);
        if (b == 8'h7D) b = 8'h00;
        s.push_back(b);
      end
      s.push_back(8'h7D);
      len = $urandom_range(0, 6);
      for (int k = 0; k < len; k++) begin
        case ($urandom_range(0, 7))
          0: begin s.push_back(8'h7F); s.push_back(8'h7D); end
          1: begin s.push_back(8'h7F); s.push_back(8'h7E); end
          2: begin s.push_back(8'h7F); s.push_back(8'h7F); end
          3: begin s.push_back(8'h7F); s.push_back(8'($urandom_range(0, 8'h7C))); end
          default: s.push_back(8'($urandom_range(0, 8'h7C)));
        endcase
      end
      s.push_back(($urandom_range(0, 7) == 0) ? 8'h7D : 8'h7E);
    end
    s.push_back(8'h7E);
    model(s);
    clear_obs();
    ready_mode = 1;
    send_stream(s, 2);
    drain(exp_q.size());
    ready_mode = 0;
    repeat (3) @(negedge aclk);
    total++;
    if (obs.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL random_count: got %0d want %0d", obs.size(), exp_q.size());
    end
    nbad = 0;
    foreach (exp_q[i]) begin
      total++;
      if (i >= obs.size() || obs[i] !== exp_q[i]) begin
        bad++;
        nbad++;
        if (nbad <= 8)
          $display("FAIL random_byte%0d: got %h want %h", i, (i < obs.size()) ? obs[i] : 9'h1FF, exp_q[i]);
      end
    end
    total++;
    if (err_seen !== exp_errs) begin
      bad++;
      $display("FAIL random_err: got %0d want %0d", err_seen, exp_errs);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] s[$];
    ready_mode = 2;
    repeat (2) @(posedge aclk);
    #1;
    clear_obs();
    s = '{8'h7D, 8'h11, 8'h22};
    send_stream(s, 0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    @(negedge aclk);
    total++;
    if ({initiator_tvalid, initiator_tdata, initiator_tlast, frame_error, target_tready} !== 12'h000) begin
      bad++;
      $display("FAIL midreset_outputs: got v=%0b d=%h l=%0b err=%0b trdy=%0b, want all 0",
               initiator_tvalid, initiator_tdata, initiator_tlast, frame_error, target_tready);
    end
    ready_mode = 0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    clear_obs();
    s = '{8'h7D, 8'h33, 8'h7E};
    send_stream(s, 0);
    drain(1);
    total++;
    if (obs.size() !== 1 || obs[0] !== 9'h133 || err_seen !== 0) begin
      bad++;
      $display("FAIL after_reset: got out=%0d first=%h err=%0d want out=1 first=133 err=0",
               obs.size(), (obs.size() > 0) ? obs[0] : 9'h1FF, err_seen);
    end
  endtask

  initial begin
    fork
      ready_loop();
      monitor_loop();
      begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
      end
    join_none
    test_reset();
    test_basic();
    test_escape();
    test_junk();
    test_errors();
    test_truncated();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
